// File: rtl/score_segment_decoder_pkg.sv
// score_segment_decoder_pkg: active-low seven-segment glyphs and decoder FSM states
package score_segment_decoder_pkg;
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] BLANK   = 7'h7F;
  typedef enum logic [1:0] {SCAN, CONVERT, EMIT} state_t;
endpackage

// File: rtl/score_segment_decoder_seg7_to_digit.sv
// seg7_to_digit: maps active-low {g,f,e,d,c,b,a} to {illegal, digit}; blank reads as 0
module seg7_to_digit
  import score_segment_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic       illegal,
  output logic [3:0] digit
);
  // glyph lookup; anything outside the ten glyphs and blank is flagged illegal
  always_comb begin
    {illegal, digit} = seg == GLYPH_0 ? 5'd0 :
                       seg == GLYPH_1 ? 5'd1 :
                       seg == GLYPH_2 ? 5'd2 :
                       seg == GLYPH_3 ? 5'd3 :
                       seg == GLYPH_4 ? 5'd4 :
                       seg == GLYPH_5 ? 5'd5 :
                       seg == GLYPH_6 ? 5'd6 :
                       seg == GLYPH_7 ? 5'd7 :
                       seg == GLYPH_8 ? 5'd8 :
                       seg == GLYPH_9 ? 5'd9 :
                       seg == BLANK   ? 5'd0 : 5'h10;
  end
endmodule

// File: rtl/score_segment_decoder.sv
// score_segment_decoder: rebuilds a 4-digit score from a multiplexed 7-seg bus; SCAN_TIMEOUT_EN adds a scan watchdog
module score_segment_decoder
  import score_segment_decoder_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_segment,
  input  logic [3:0] i_segment_an,
  output logic [9:0] o_score,
  output logic       o_valid,
  output logic       o_err
`ifdef SCAN_TIMEOUT_EN
  , output logic     o_timeout
`endif
);
  localparam int SW = $clog2(SETTLE + 1);
  logic [7:0]      seg_q;
  logic [3:0]      an_q;
  logic [11:0]     prev_q;
  logic [SW-1:0]   cnt;
  logic [SW-1:0]   cnt_n;
  logic [3:0]      hot;
  logic            sel;
  logic [1:0]      pos;
  logic            cap;
  logic            fire;
  logic            illegal;
  logic [3:0]      digit;
  logic [3:0][3:0] digits;
  logic [3:0]      mask;
  logic            ferr;
  logic [13:0]     value;
  state_t          state;

  seg7_to_digit u_dec (
    .seg     (seg_q[6:0]),
    .illegal (illegal),
    .digit   (digit)
  );

  // settle tracking: counter saturates at SETTLE so a long dwell captures exactly once
  always_comb begin
    hot   = ~an_q;
    sel   = $onehot(hot);
    pos   = hot[0] ? 2'd0 : hot[1] ? 2'd1 : hot[2] ? 2'd2 : 2'd3;
    cnt_n = (!sel || {an_q, seg_q} != prev_q) ? '0 :
            cnt == SW'(SETTLE) ? cnt : cnt + 1'b1;
    cap   = sel && state == SCAN && cnt_n == SW'(SETTLE - 1);
  end

`ifdef SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle;
  assign fire = !cap && idle == TW'(TIMEOUT - 1);
  // watchdog: counts cycles since the last capture, flag sticks until the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      idle      <= '0;
      o_timeout <= 1'b0;
    end else if (cap) begin
      idle      <= '0;
      o_timeout <= 1'b0;
    end else begin
      idle <= idle == TW'(TIMEOUT) ? idle : idle + 1'b1;
      if (fire) o_timeout <= 1'b1;
    end
  end
`else
  assign fire = 1'b0;
`endif

  // input registers, digit capture and the SCAN/CONVERT/EMIT frame sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= 8'hFF;
      an_q    <= 4'hF;
      prev_q  <= 12'hFFF;
      cnt     <= '0;
      digits  <= '0;
      mask    <= '0;
      ferr    <= 1'b0;
      value   <= '0;
      state   <= SCAN;
      o_score <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      seg_q   <= i_segment;
      an_q    <= i_segment_an;
      prev_q  <= {an_q, seg_q};
      cnt     <= cnt_n;
      o_valid <= 1'b0;
      if (state == SCAN) begin
        if (cap) begin
          digits[pos] <= digit;
          mask        <= mask | hot;
          ferr        <= ferr | illegal;
          if ((mask | hot) == 4'hF) state <= CONVERT;
        end else if (fire) begin
          mask <= '0;
        end
      end else if (state == CONVERT) begin
        value <= 14'(digits[3]) * 14'd1000 + 14'(digits[2]) * 14'd100 +
                 14'(digits[1]) * 14'd10 + 14'(digits[0]);
        state <= EMIT;
      end else begin
        if (!ferr && value <= 14'd1023) begin
          o_score <= value[9:0];
          o_valid <= 1'b1;
          o_err   <= 1'b0;
        end else begin
          o_err <= 1'b1;
        end
        digits <= '0;
        mask   <= '0;
        ferr   <= 1'b0;
        state  <= SCAN;
      end
    end
  end
endmodule

// File: tb/tb_score_segment_decoder.sv
// tb_score_segment_decoder: scoreboard bench for score_segment_decoder; SCAN_TIMEOUT_EN adds watchdog checks
module tb_score_segment_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] seg = 8'hFF;
  logic [3:0] an  = 4'hF;
  logic [9:0] score;
  logic       valid;
  logic       err;

  always #5 clk = ~clk;

`ifdef SCAN_TIMEOUT_EN
  logic tmo;
  score_segment_decoder #(.SETTLE(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .i_segment(seg), .i_segment_an(an),
    .o_score(score), .o_valid(valid), .o_err(err), .o_timeout(tmo)
  );
`else
  score_segment_decoder #(.SETTLE(4)) dut (
    .clk(clk), .rst(rst), .i_segment(seg), .i_segment_an(an),
    .o_score(score), .o_valid(valid), .o_err(err)
  );
`endif

  typedef struct packed {
    logic [9:0] score;
    logic       valid;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   events      = 0;
  logic err_q       = 1'b0;

  // monitor: an output event is an o_valid pulse or a rising o_err
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (valid || (err && !err_q))) begin
      events++;
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output got score=%0d valid=%0b err=%0b, expected no output", score, valid, err);
      end else begin
        e = q.pop_front();
        if ({score, valid, err} !== e) begin
          miscompares++;
          $display("FAIL frame_output got score=%0d valid=%0b err=%0b, expected score=%0d valid=%0b err=%0b",
                   score, valid, err, e.score, e.valid, e.err);
        end
      end
    end
    err_q = err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [9:0] s, input logic v, input logic e);
    exp_t x;
    x.score = s;
    x.valid = v;
    x.err   = e;
    q.push_back(x);
  endtask

  task automatic show(input int p, input logic [7:0] s, input int dwell);
    logic [3:0] h;
    h   = 4'b1 << p;
    an  = ~h;
    seg = s;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] s3, input logic [7:0] s2, input logic [7:0] s1,
                       input logic [7:0] s0, input int dwell);
    show(3, s3, dwell);
    show(2, s2, dwell);
    show(1, s1, dwell);
    show(0, s0, dwell);
    an  = 4'hF;
    seg = 8'hFF;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("reset_score", score, 0);
    check("reset_valid", valid, 0);
    check("reset_err", err, 0);
`ifdef SCAN_TIMEOUT_EN
    check("reset_timeout", tmo, 0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
    expect_out(10'd12, 1'b1, 1'b0);
    frame(8'hFF, 8'hC0, 8'hF9, 8'hA4, 8);
    expect_out(10'd1023, 1'b1, 1'b0);
    frame(8'h79, 8'hC0, 8'hA4, 8'hB0, 8);
    expect_out(10'd1023, 1'b0, 1'b1);
    frame(8'hF9, 8'hC0, 8'hA4, 8'h99, 8);
    expect_out(10'd2, 1'b1, 1'b0);
    frame(8'hC0, 8'hC0, 8'hC0, 8'hA4, 8);
    expect_out(10'd2, 1'b0, 1'b1);
    frame(8'hC0, 8'hC0, 8'hFE, 8'h92, 8);
    expect_out(10'd2, 1'b1, 1'b0);
    frame(8'hFF, 8'hFF, 8'hFF, 8'hA4, 8);
    n = events;
    frame(8'hC0, 8'hC0, 8'hC0, 8'h90, 3);
    check("short_dwell_no_capture", events, n);
    expect_out(10'd7, 1'b1, 1'b0);
    frame(8'hC0, 8'hC0, 8'hC0, 8'hF8, 4);
    show(0, 8'hA4, 8);
    show(1, 8'hA4, 8);
    show(2, 8'hF9, 8);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_rst_score", score, 0);
    check("midframe_rst_valid", valid, 0);
    check("midframe_rst_err", err, 0);
    rst = 1'b0;
    n = events;
    show(3, 8'hF9, 8);
    an  = 4'hF;
    seg = 8'hFF;
    repeat (8) @(negedge clk);
    check("aborted_frame_no_output", events, n);
`ifdef SCAN_TIMEOUT_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("timeout_before_limit", tmo, 0);
    @(negedge clk);
    check("timeout_at_limit", tmo, 1);
    show(0, 8'hF9, 8);
    check("timeout_cleared_by_capture", tmo, 0);
`endif
    repeat (4) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
